water_level_ctrl: RTL and testbench
===================================

Name: water_level_ctrl

Overview:
Parametrised successor to the 8-probe water level indicator. It samples N thermometer-coded level probes and checks that the pattern is a legal thermometer code. It debounces the encoded level and publishes full/half/empty flags. It also drives a pump through a hysteresis state machine with a fill timeout and a latched fault. It sits between the raw probe inputs and the tank actuator/status logic.

Parameters:
N_SENS, 8, number of level probes (>=2); bit i set means water at or above probe i.
LVL_W, $clog2(N_SENS+1), width of the level output.
DEBOUNCE, 4, consecutive identical encoded samples required before the level is committed (>=1).
LOW_TH, 2, level at or below which filling starts (LOW_TH < HIGH_TH).
HIGH_TH, 6, level at or above which filling stops (HIGH_TH <= N_SENS).
FILL_TIMEOUT, 64, maximum cycles in FILL before a fault is raised.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  pump control enable; when 0 the FSM is held in IDLE (status logic still runs).
sensors  in  N_SENS  raw probe inputs.
clr_fault  in  1  single-cycle pulse that clears the latched fault.
level  out  LVL_W  debounced level, 0..N_SENS.
level_vld  out  1  high once the first level has been committed after reset.
full  out  1  level == N_SENS.
half  out  1  level >= N_SENS/2 (integer division).
empty  out  1  level == 0.
sens_err  out  1  debounced flag for a non-thermometer probe pattern.
pump_on  out  1  pump drive.
fault  out  1  latched fault (timeout or sensor error).

Behaviour:
- Reset (synchronous) values:
  - level=0, level_vld=0, full=0, half=0, empty=1, sens_err=0, pump_on=0, fault=0.
  - FSM in IDLE; internal counters cleared.
  - Reset asserted mid-fill drops pump_on on the following edge.
- Stage 1: sensors registered into samp.
- Encoder (combinational on samp):
  - enc_lvl = index of highest set bit + 1, or 0 if samp is all zero.
  - enc_bad = 1 if any 0 lies below the highest 1 (e.g. 8'b0001_0001).
- Debounce on the pair {enc_bad, enc_lvl}, using candidate register cand and counter cnt:
  - If the pair differs from cand: cand <= pair, cnt <= 0.
  - Else if cnt < DEBOUNCE-1: cnt++.
  - Else commit: level <= cand level, sens_err <= cand bad, level_vld <= 1.
  - While a bad pattern is committed, level keeps its last good value.
  - Latency: a stable input change appears on level DEBOUNCE+2 edges after it is applied (6 at default). Shorter glitches never reach level.
- Flags full/half/empty are decoded from the level register, so they change in the same cycle as level.
- FSM states: IDLE, FILL, FAULT. pump_on = (state==FILL), registered, so it changes one edge after the triggering level.
  - IDLE -> FILL: en & level_vld & !sens_err & level <= LOW_TH.
  - FILL -> IDLE: level >= HIGH_TH, or en==0.
  - FILL -> FAULT: timer reaches FILL_TIMEOUT-1. The timer counts cycles in FILL and is cleared on entry.
  - Any state -> FAULT: sens_err==1.
  - FAULT -> IDLE: clr_fault & !sens_err. If clr_fault arrives while sens_err==1, it is ignored.
  - FAULT outranks all other transitions in the same cycle.
  - fault = (state==FAULT).
- Hysteresis: levels strictly between LOW_TH and HIGH_TH hold the current state.
- Width rules:
  - Comparisons are unsigned at LVL_W.
  - Timer width is $clog2(FILL_TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Shared package water_pkg holds:
  - the FSM state typedef/localparams (IDLE=2'd0, FILL=2'd1, FAULT=2'd2);
  - a function computing LVL_W.
- Sub-module thermo_encoder (parametrised N_SENS) produces enc_lvl/enc_bad combinationally.
- Debounce, flags and FSM live in the top module.

Test Plan:
- Reset with sensors=8'h00 held for 10 cycles, en=1 -> level=0 and empty=1; level_vld rises at edge 6 after reset release; pump_on=1 one edge later.
- Fill ramp with en=1: sensors 8'h01 -> 8'h0F -> 8'h3F, each held 10 cycles -> level goes 1, 4, 6; half=1 at level 4; pump_on falls one edge after level=6.
- Glitch: with level 4 committed, sensors=8'h3F for 3 cycles then back to 8'h0F -> level stays 4 throughout.
- Bad pattern: sensors=8'b0001_0001 for 8 cycles -> sens_err=1, fault=1, pump_on=0, level holds previous value. Then restore 8'h03 and pulse clr_fault -> FSM returns to IDLE; refill starts.
- Timeout: en=1, sensors held at 8'h01 -> pump_on=1; after 64 cycles in FILL fault=1 and pump_on=0; clr_fault -> IDLE, then FILL again.
- Full with simultaneous events: sensors=8'hFF -> full=1, half=1, empty=0. Then assert rst in the same cycle as clr_fault during FILL -> all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/water_pkg.sv
// Shared definitions for the water level controller: FSM encodings and level width helper.
package water_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FILL  = 2'd1;
  localparam state_t FAULT = 2'd2;

  function automatic int unsigned lvl_width(input int unsigned n_sens);
    return $clog2(n_sens + 1);
  endfunction

endpackage

// File: rtl/thermo_encoder.sv
// Thermometer-code encoder: level = highest set probe + 1, bad = a gap below the top probe.
module thermo_encoder #(
  parameter int unsigned N_SENS = 8,
  parameter int unsigned LVL_W  = 4
) (
  input  logic [N_SENS-1:0] samp_i,
  output logic [LVL_W-1:0]  enc_lvl_c,
  output logic              enc_bad_c
);

  logic [LVL_W-1:0] lvl;

  always_comb begin
    lvl       = '0;
    enc_bad_c = 1'b0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      if (samp_i[i]) lvl = LVL_W'(i + 1);
    end
    for (int unsigned i = 0; i < N_SENS; i++) begin
      if (!samp_i[i] && (LVL_W'(i) < lvl)) enc_bad_c = 1'b1;
    end
    enc_lvl_c = lvl;
  end

endmodule

// File: rtl/water_level_ctrl.sv
// Tank level controller: probe sampling, debounced level/flags and a hysteresis pump FSM
// with fill timeout and latched fault.
module water_level_ctrl
  import water_pkg::*;
#(
  parameter int unsigned N_SENS       = 8,
  parameter int unsigned LVL_W        = lvl_width(N_SENS),
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned LOW_TH       = 2,
  parameter int unsigned HIGH_TH      = 6,
  parameter int unsigned FILL_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_SENS-1:0] sensors,
  input  logic              clr_fault,
  output logic [LVL_W-1:0]  level,
  output logic              level_vld,
  output logic              full,
  output logic              half,
  output logic              empty,
  output logic              sens_err,
  output logic              pump_on,
  output logic              fault
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TMR_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(N_SENS);
  localparam logic [LVL_W-1:0] LVL_HALF = LVL_W'(N_SENS / 2);
  localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_TH);
  localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(HIGH_TH);

  logic [N_SENS-1:0] samp_q;
  logic              samp_vld_q;
  logic [LVL_W-1:0]  enc_lvl;
  logic              enc_bad;

  logic [LVL_W-1:0]  cand_lvl_q, cand_lvl_d;
  logic              cand_bad_q, cand_bad_d;
  logic              cand_vld_q, cand_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              level_vld_q, level_vld_d;
  logic              sens_err_q, sens_err_d;
  logic              full_q, full_d, half_q, half_d, empty_q, empty_d;
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pump_on_q, pump_on_d;
  logic              fault_q, fault_d;

  thermo_encoder #(
    .N_SENS (N_SENS),
    .LVL_W  (LVL_W)
  ) u_enc (
    .samp_i    (samp_q),
    .enc_lvl_c (enc_lvl),
    .enc_bad_c (enc_bad)
  );

  // Debounce on {bad, level}; a bad pattern freezes the last good level.
  always_comb begin
    cand_lvl_d  = cand_lvl_q;
    cand_bad_d  = cand_bad_q;
    cand_vld_d  = cand_vld_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_vld_d = level_vld_q;
    sens_err_d  = sens_err_q;
    if (samp_vld_q) begin
      if (!cand_vld_q || (enc_bad != cand_bad_q) || (enc_lvl != cand_lvl_q)) begin
        cand_lvl_d = enc_lvl;
        cand_bad_d = enc_bad;
        cand_vld_d = 1'b1;
        cnt_d      = '0;
      end else if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        level_vld_d = 1'b1;
        sens_err_d  = cand_bad_q;
        if (!cand_bad_q) level_d = cand_lvl_q;
      end
    end
    full_d  = (level_d == LVL_FULL);
    half_d  = (level_d >= LVL_HALF);
    empty_d = (level_d == '0);
  end

  // Pump FSM: sensor error wins, then timeout, then hysteresis thresholds.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    if (state_q == FILL) timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
    if (sens_err_q) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE:    if (en && level_vld_q && (level_q <= LVL_LOW)) state_d = FILL;
        FILL:    if (timer_q == TMR_LAST) state_d = FAULT;
                 else if ((level_q >= LVL_HIGH) || !en) state_d = IDLE;
        FAULT:   if (clr_fault) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    pump_on_d = (state_d == FILL);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q      <= '0;
      samp_vld_q  <= 1'b0;
      cand_lvl_q  <= '0;
      cand_bad_q  <= 1'b0;
      cand_vld_q  <= 1'b0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_vld_q <= 1'b0;
      sens_err_q  <= 1'b0;
      full_q      <= 1'b0;
      half_q      <= 1'b0;
      empty_q     <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      pump_on_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      samp_q      <= sensors;
      samp_vld_q  <= 1'b1;
      cand_lvl_q  <= cand_lvl_d;
      cand_bad_q  <= cand_bad_d;
      cand_vld_q  <= cand_vld_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_vld_q <= level_vld_d;
      sens_err_q  <= sens_err_d;
      full_q      <= full_d;
      half_q      <= half_d;
      empty_q     <= empty_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      pump_on_q   <= pump_on_d;
      fault_q     <= fault_d;
    end
  end

  assign level     = level_q;
  assign level_vld = level_vld_q;
  assign full      = full_q;
  assign half      = half_q;
  assign empty     = empty_q;
  assign sens_err  = sens_err_q;
  assign pump_on   = pump_on_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed bench for water_level_ctrl: reset, fill ramp, glitch, bad pattern, timeout, full and reset-in-fill.
module tb_water_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] sensors;
  logic       clr_fault;
  logic [3:0] level;
  logic       level_vld, full, half, empty, sens_err, pump_on, fault;

  int n_chk  = 0;
  int n_fail = 0;

  water_level_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sensors   (sensors),
    .clr_fault (clr_fault),
    .level     (level),
    .level_vld (level_vld),
    .full      (full),
    .half      (half),
    .empty     (empty),
    .sens_err  (sens_err),
    .pump_on   (pump_on),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".level"},     32'(level),     32'd0);
    chk({tag, ".level_vld"}, 32'(level_vld), 32'd0);
    chk({tag, ".full"},      32'(full),      32'd0);
    chk({tag, ".half"},      32'(half),      32'd0);
    chk({tag, ".empty"},     32'(empty),     32'd1);
    chk({tag, ".sens_err"},  32'(sens_err),  32'd0);
    chk({tag, ".pump_on"},   32'(pump_on),   32'd0);
    chk({tag, ".fault"},     32'(fault),     32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sensors = 8'h00; clr_fault = 1'b0;
    step(3);
    chk_reset("rst");
    rst = 1'b0;

    // level_vld rises on the 6th edge after release, pump one edge later
    step(5);
    chk("vld_e5", 32'(level_vld), 32'd0);
    step(1);
    chk("vld_e6", 32'(level_vld), 32'd1);
    chk("lvl_e6", 32'(level), 32'd0);
    chk("pump_e6", 32'(pump_on), 32'd0);
    step(1);
    chk("pump_e7", 32'(pump_on), 32'd1);

    // fill ramp
    sensors = 8'h01;
    step(6);
    chk("ramp1.level", 32'(level), 32'd1);
    chk("ramp1.empty", 32'(empty), 32'd0);
    chk("ramp1.half",  32'(half),  32'd0);
    step(4);
    sensors = 8'h0F;
    step(5);
    chk("ramp4.early", 32'(level), 32'd1);
    step(1);
    chk("ramp4.level", 32'(level), 32'd4);
    chk("ramp4.half",  32'(half),  32'd1);
    chk("ramp4.pump",  32'(pump_on), 32'd1);
    step(4);
    sensors = 8'h3F;
    step(6);
    chk("ramp6.level", 32'(level), 32'd6);
    chk("ramp6.pump",  32'(pump_on), 32'd1);
    step(1);
    chk("ramp6.pump_off", 32'(pump_on), 32'd0);
    step(3);

    // back to level 4: hysteresis keeps pump off
    sensors = 8'h0F;
    step(6);
    chk("hyst.level", 32'(level), 32'd4);
    step(1);
    chk("hyst.pump", 32'(pump_on), 32'd0);

    // glitch shorter than debounce
    sensors = 8'h3F;
    step(3);
    sensors = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch.level", 32'(level), 32'd4);
    end

    // non-thermometer pattern
    sensors = 8'b0001_0001;
    step(6);
    chk("bad.sens_err", 32'(sens_err), 32'd1);
    chk("bad.level",    32'(level),    32'd4);
    step(1);
    chk("bad.fault", 32'(fault),   32'd1);
    chk("bad.pump",  32'(pump_on), 32'd0);
    step(1);
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    chk("bad.clr_ignored", 32'(fault), 32'd1);
    sensors = 8'h03;
    step(6);
    chk("rec.sens_err", 32'(sens_err), 32'd0);
    chk("rec.level",    32'(level),    32'd2);
    chk("rec.fault",    32'(fault),    32'd1);
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    chk("rec.fault_clr", 32'(fault),   32'd0);
    chk("rec.idle",      32'(pump_on), 32'd0);
    step(1);
    chk("rec.refill", 32'(pump_on), 32'd1);

    // fill timeout: 64 cycles in FILL
    sensors = 8'h01;
    step(63);
    chk("to.pump_63",  32'(pump_on), 32'd1);
    chk("to.fault_63", 32'(fault),   32'd0);
    step(1);
    chk("to.fault_64", 32'(fault),   32'd1);
    chk("to.pump_64",  32'(pump_on), 32'd0);
    chk("to.level",    32'(level),   32'd1);
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    chk("to.clr", 32'(fault), 32'd0);
    step(1);
    chk("to.refill", 32'(pump_on), 32'd1);

    // full tank
    sensors = 8'hFF;
    step(6);
    chk("full.level", 32'(level), 32'd8);
    chk("full.full",  32'(full),  32'd1);
    chk("full.half",  32'(half),  32'd1);
    chk("full.empty", 32'(empty), 32'd0);
    step(1);
    chk("full.pump_off", 32'(pump_on), 32'd0);

    // drain to empty, refill, en drop, then reset during FILL together with clr_fault
    sensors = 8'h00;
    step(6);
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.full",  32'(full),  32'd0);
    step(1);
    chk("drain.pump", 32'(pump_on), 32'd1);
    en = 1'b0;
    step(1);
    chk("en_off.pump", 32'(pump_on), 32'd0);
    en = 1'b1;
    step(1);
    chk("en_on.pump", 32'(pump_on), 32'd1);
    rst = 1'b1; clr_fault = 1'b1;
    step(1);
    chk_reset("rst_fill");
    rst = 1'b0; clr_fault = 1'b0;
    step(2);
    chk("post_rst.vld", 32'(level_vld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
